// File: rtl/bp_be_fe_queue_checker.sv
// Backend end of the FE queue: forwards on-path fetch/exception messages, drops
// wrong-path ones, and emits pc_redirect / attaboy commands back to the frontend.
module bp_be_fe_queue_checker #(
  parameter int unsigned eaddr_width_p    = 64,
  parameter int unsigned instr_width_p    = 32,
  parameter int unsigned metadata_width_p = 36,
  parameter logic [63:0] bp_first_pc_p    = 64'h8000_0000,
  parameter int unsigned cnt_width_p      = 16
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        fe_queue_v_i,
  output logic                        fe_queue_ready_o,
  input  logic                        fe_queue_exc_i,
  input  logic [eaddr_width_p-1:0]    fe_queue_pc_i,
  input  logic [instr_width_p-1:0]    fe_queue_instr_i,
  input  logic [metadata_width_p-1:0] fe_queue_metadata_i,
  output logic                        instr_v_o,
  input  logic                        instr_ready_i,
  output logic [eaddr_width_p-1:0]    instr_pc_o,
  output logic [instr_width_p-1:0]    instr_o,
  output logic                        instr_exc_o,
  input  logic                        resolve_v_i,
  input  logic [eaddr_width_p-1:0]    resolve_npc_i,
  output logic                        fe_cmd_v_o,
  input  logic                        fe_cmd_ready_i,
  output logic [eaddr_width_p-1:0]    fe_cmd_pc_o,
  output logic [metadata_width_p-1:0] fe_cmd_metadata_o,
  output logic                        fe_cmd_redirect_o,
  output logic                        fe_cmd_attaboy_o,
  output logic [cnt_width_p-1:0]      drop_cnt_o,
  output logic [cnt_width_p-1:0]      redirect_cnt_o
);

  typedef enum logic [1:0] {S_RUN, S_FWD, S_WAIT, S_CMD} state_e;

  state_e                      r_state;
  logic [eaddr_width_p-1:0]    r_expected_pc;
  logic                        r_redirect_pend;
  logic                        r_attaboy_pend;
  logic [metadata_width_p-1:0] r_fwd_meta;
  logic [eaddr_width_p-1:0]    r_res_pc;
  logic [metadata_width_p-1:0] r_res_meta;
  logic                        r_is_ctrl;

  logic w_in_run;
  logic w_match;
  logic w_fwd_is_ctrl;

  assign w_in_run = (r_state == S_RUN);
  assign w_match  = (fe_queue_pc_i == r_expected_pc);
  // Attaboy must be sent before the matching head is consumed, so hold it then.
  assign fe_queue_ready_o = w_in_run & fe_queue_v_i & (~w_match | ~r_attaboy_pend);
  assign w_fwd_is_ctrl = ~instr_exc_o & ((instr_o[6:0] == 7'b1100011) |
                                         (instr_o[6:0] == 7'b1101111) |
                                         (instr_o[6:0] == 7'b1100111));

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state           <= S_RUN;
      r_expected_pc     <= eaddr_width_p'(bp_first_pc_p);
      r_redirect_pend   <= 1'b0;
      r_attaboy_pend    <= 1'b0;
      r_fwd_meta        <= '0;
      r_res_pc          <= '0;
      r_res_meta        <= '0;
      r_is_ctrl         <= 1'b0;
      instr_v_o         <= 1'b0;
      instr_pc_o        <= '0;
      instr_o           <= '0;
      instr_exc_o       <= 1'b0;
      fe_cmd_v_o        <= 1'b0;
      fe_cmd_pc_o       <= '0;
      fe_cmd_metadata_o <= '0;
      fe_cmd_redirect_o <= 1'b0;
      fe_cmd_attaboy_o  <= 1'b0;
      drop_cnt_o        <= '0;
      redirect_cnt_o    <= '0;
    end else begin
      unique case (r_state)
        S_RUN: begin
          if (fe_queue_v_i && w_match && r_attaboy_pend) begin
            fe_cmd_v_o        <= 1'b1;
            fe_cmd_pc_o       <= r_res_pc;
            fe_cmd_metadata_o <= r_res_meta;
            fe_cmd_redirect_o <= 1'b0;
            fe_cmd_attaboy_o  <= 1'b1;
            r_state           <= S_CMD;
          end else if (fe_queue_v_i && w_match) begin
            r_redirect_pend <= 1'b0;
            instr_v_o       <= 1'b1;
            instr_pc_o      <= fe_queue_pc_i;
            instr_o         <= fe_queue_instr_i;
            instr_exc_o     <= fe_queue_exc_i;
            r_fwd_meta      <= fe_queue_metadata_i;
            r_state         <= S_FWD;
          end else if (fe_queue_v_i) begin
            if (drop_cnt_o != '1) drop_cnt_o <= drop_cnt_o + cnt_width_p'(1);
            // Only the first wrong-path message of a run triggers a redirect.
            if (!r_redirect_pend) begin
              fe_cmd_v_o        <= 1'b1;
              fe_cmd_pc_o       <= r_expected_pc;
              fe_cmd_metadata_o <= r_res_meta;
              fe_cmd_redirect_o <= 1'b1;
              fe_cmd_attaboy_o  <= 1'b0;
              r_redirect_pend   <= 1'b1;
              if (redirect_cnt_o != '1) redirect_cnt_o <= redirect_cnt_o + cnt_width_p'(1);
              r_state           <= S_CMD;
            end
          end
        end
        S_FWD: begin
          if (instr_ready_i) begin
            instr_v_o  <= 1'b0;
            r_res_pc   <= instr_pc_o;
            r_res_meta <= r_fwd_meta;
            r_is_ctrl  <= w_fwd_is_ctrl;
            r_state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (resolve_v_i) begin
            r_expected_pc  <= resolve_npc_i;
            r_attaboy_pend <= r_is_ctrl;
            r_state        <= S_RUN;
          end
        end
        S_CMD: begin
          // Both redirect and attaboy retire any outstanding attaboy.
          if (fe_cmd_ready_i) begin
            fe_cmd_v_o        <= 1'b0;
            fe_cmd_redirect_o <= 1'b0;
            fe_cmd_attaboy_o  <= 1'b0;
            r_attaboy_pend    <= 1'b0;
            r_state           <= S_RUN;
          end
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

endmodule
